ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/simplecpu_pkg.sv | 9 +
 rtl/rr_arb2.sv | 34 +++
 rtl/ram_arbiter.sv | 59 +++++
 3 files changed

// File: rtl/simplecpu_pkg.sv
// simplecpu_pkg: shared RAM geometry and requester identifiers.
//   DATA_W, ADDR_W, DEPTH : default RAM word width, address width, word count
//   port_e                : requester index (PORT_HOST=0, PORT_CPU=1)
package simplecpu_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {PORT_HOST = 1'b0, PORT_CPU = 1'b1} port_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter with host burst lock and fixed-priority option.
//   clk, reset      : clock, asynchronous active-low reset
//   h_req, h_lock   : host request and burst lock
//   c_req           : CPU request
//   h_gnt, c_gnt    : combinational one-hot grants (both 0 in reset)
module rr_arb2 import simplecpu_pkg::*; #(
  parameter int HOST_PRIO = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic h_req,
  input  logic h_lock,
  input  logic c_req,
  output logic h_gnt,
  output logic c_gnt
);
  port_e last_winner;
  logic locked;
  // Host wins when locked, alone, favoured by priority, or when the CPU won last.
  always_comb begin
    h_gnt = reset & h_req & (locked | !c_req | (HOST_PRIO != 0) | (last_winner == PORT_CPU));
    c_gnt = reset & c_req & !locked & !h_gnt;
  end
  // A granted host with h_lock keeps the lock; any cycle without that drops it.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      locked <= 1'b0;
      last_winner <= PORT_CPU;
    end else begin
      locked <= h_gnt & h_lock;
      if (h_gnt) last_winner <= PORT_HOST;
      else if (c_gnt) last_winner <= PORT_CPU;
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: single-port RAM shared by a host (loader) and a CPU, one access per clock.
//   clk, reset                          : clock, asynchronous active-low reset
//   h_req/h_we/h_addr/h_wdata/h_lock    : host request, write enable, address, data, burst lock
//   h_gnt/h_rvalid/h_rdata              : host grant, registered read valid and data
//   c_req/c_we/c_addr/c_wdata           : CPU request side (no lock)
//   c_gnt/c_rvalid/c_rdata              : CPU grant, registered read valid and data
module ram_arbiter #(
  parameter int DATA_W = simplecpu_pkg::DATA_W,
  parameter int ADDR_W = simplecpu_pkg::ADDR_W,
  parameter int HOST_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  input  logic              h_lock,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic wr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  rr_arb2 #(.HOST_PRIO(HOST_PRIO)) u_arb (
    .clk(clk), .reset(reset), .h_req(h_req), .h_lock(h_lock), .c_req(c_req),
    .h_gnt(h_gnt), .c_gnt(c_gnt)
  );
  always_comb begin
    wr = (h_gnt & h_we) | (c_gnt & c_we);
    wr_addr = h_gnt ? h_addr : c_addr;
    wr_data = h_gnt ? h_wdata : c_wdata;
  end
  // Memory contents survive reset.
  always_ff @(posedge clk)
    if (wr) mem[wr_addr] <= wr_data;
  // Read data only updates on a granted read, so it holds between reads.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      h_rvalid <= 1'b0;
      c_rvalid <= 1'b0;
      h_rdata <= '0;
      c_rdata <= '0;
    end else begin
      h_rvalid <= h_gnt & !h_we;
      c_rvalid <= c_gnt & !c_we;
      if (h_gnt & !h_we) h_rdata <= mem[h_addr];
      if (c_gnt & !c_we) c_rdata <= mem[c_addr];
    end
endmodule
